pipe_skid_stage: RTL and testbench

//  - Parametrised elastic pipeline register between two datapath stages (F/D, D/E, E/M, M/W).
//  - Uses a valid/ready handshake with a one-entry skid buffer, so o_inReady is driven from a register.
//  - Accepts a synchronous flush that inserts a bubble (BUBBLE_VAL, e.g. NOP 32'h0000_0013).
//  - Replaces the hard-wired stage registers with a stallable, flushable stage driven by the hazard unit.

---
 rtl/pipe_skid_stage.sv | 115 +++++++++++
 tb/tb_pipe_skid_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register with a one-entry skid buffer and a synchronous flush.
// Optional saturating bubble counter on o_bubbleCnt when PIPE_BUBBLE_CNT_EN is defined.
module pipe_skid_stage #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
`ifdef PIPE_BUBBLE_CNT_EN
    ,
    parameter int               CNT_W      = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_inValid,
    output logic             o_inReady,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_outValid,
    input  logic             i_outReady,
    output logic [WIDTH-1:0] o_data
`ifdef PIPE_BUBBLE_CNT_EN
    ,
    output logic [CNT_W-1:0] o_bubbleCnt
`endif
);

    // State bits are {skid_valid, main_valid}.
    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        FULL    = 2'b01,
        ILLEGAL = 2'b10,
        SKID    = 2'b11
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] main_nxt;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_nxt;
    logic             in_rdy_q;
    logic             in_fire;
    logic             out_fire;

    assign o_outValid = state[0];
    assign o_inReady  = in_rdy_q;
    assign in_fire    = i_inValid & in_rdy_q;
    assign out_fire   = o_outValid & i_outReady;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            o_data   <= RESET_VAL;
            skid_q   <= RESET_VAL;
            in_rdy_q <= 1'b1;
        end else begin
            state    <= state_nxt;
            o_data   <= main_nxt;
            skid_q   <= skid_nxt;
            // Ready is registered from the next state, so it only drops in SKID.
            in_rdy_q <= ~state_nxt[1];
        end
    end

    always_comb begin
        state_nxt = state;
        main_nxt  = o_data;
        skid_nxt  = skid_q;
        if (i_flush) begin
            state_nxt = EMPTY;
            main_nxt  = BUBBLE_VAL;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt = FULL;
                        main_nxt  = i_data;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        main_nxt = i_data;
                    end else if (in_fire) begin
                        state_nxt = SKID;
                        skid_nxt  = i_data;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        state_nxt = FULL;
                        main_nxt  = skid_q;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_BUBBLE_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Counts cycles where downstream could take data but none is offered.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_bubbleCnt <= '0;
        end else if (~o_outValid && i_outReady && ~&o_bubbleCnt) begin
            o_bubbleCnt <= o_bubbleCnt + CNT_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: FIFO order, stalls, flush, reset.
// Exercises the bubble counter when PIPE_BUBBLE_CNT_EN is defined.
module tb_pipe_skid_stage;

    localparam int          W     = 32;
    localparam logic [31:0] RST_V = 32'hDEAD_0000;
    localparam logic [31:0] BUB_V = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_flush;
    logic          i_inValid;
    logic          o_inReady;
    logic [W-1:0]  i_data;
    logic          o_outValid;
    logic          i_outReady;
    logic [W-1:0]  o_data;
`ifdef PIPE_BUBBLE_CNT_EN
    logic [1:0]    o_bubbleCnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_skid_stage #(
        .WIDTH(W),
        .RESET_VAL(RST_V),
        .BUBBLE_VAL(BUB_V)
`ifdef PIPE_BUBBLE_CNT_EN
        ,
        .CNT_W(2)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_flush(i_flush),
        .i_inValid(i_inValid),
        .o_inReady(o_inReady),
        .i_data(i_data),
        .o_outValid(o_outValid),
        .i_outReady(i_outReady),
        .o_data(o_data)
`ifdef PIPE_BUBBLE_CNT_EN
        ,
        .o_bubbleCnt(o_bubbleCnt)
`endif
    );

    // Scoreboard: at mid-cycle, pop on out_fire, drop all on flush/reset,
    // push on an in_fire that will not be discarded.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (reset !== 1'b1 && o_outValid === 1'b1 && i_outReady === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_extra: got %h, expected no output", o_data);
            end else begin
                e = exp_q.pop_front();
                if (o_data !== e) begin
                    n_err++;
                    $display("FAIL sb_data: got %h, expected %h", o_data, e);
                end
            end
        end
        if (reset === 1'b1 || i_flush === 1'b1) begin
            exp_q.delete();
        end else if (i_inValid === 1'b1 && o_inReady === 1'b1) begin
            exp_q.push_back(i_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
        i_inValid  = v;
        i_data     = d;
        i_outReady = r;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        i_flush = 1'b0;
        drive(1'b1, 32'h77, 1'b1);
        tick();
        tick();
        n_vec++;
        if (o_outValid !== 1'b0 || o_data !== RST_V || o_inReady !== 1'b1) begin
            n_err++;
            $display("FAIL reset: v=%b d=%h r=%b, expected 0 %h 1",
                     o_outValid, o_data, o_inReady, RST_V);
        end
        reset = 1'b0;
        drive(1'b1, 32'hA5, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        n_vec++;
        if (o_outValid !== 1'b1 || o_data !== 32'hA5) begin
            n_err++;
            $display("FAIL first: v=%b d=%h, expected 1 000000a5", o_outValid, o_data);
        end
        i_outReady = 1'b1;
        tick();
        n_vec++;
        if (o_outValid !== 1'b0) begin
            n_err++;
            $display("FAIL drain: v=%b, expected 0", o_outValid);
        end
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, W'(i), 1'b1);
            tick();
            n_vec++;
            if (o_outValid !== 1'b1 || o_data !== W'(i) || o_inReady !== 1'b1) begin
                n_err++;
                $display("FAIL stream: v=%b d=%h r=%b, expected 1 %h 1",
                         o_outValid, o_data, o_inReady, W'(i));
            end
        end
        drive(1'b0, 32'h0, 1'b1);
        tick();
    endtask

    task automatic test_stall();
        drive(1'b1, 32'd10, 1'b0);
        tick();
        drive(1'b1, 32'd11, 1'b0);
        tick();
        drive(1'b1, 32'd99, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (o_outValid !== 1'b1 || o_data !== 32'd10 || o_inReady !== 1'b0) begin
                n_err++;
                $display("FAIL stall: v=%b d=%h r=%b, expected 1 0000000a 0",
                         o_outValid, o_data, o_inReady);
            end
            tick();
        end
        drive(1'b0, 32'h0, 1'b1);
        tick();
        n_vec++;
        if (o_outValid !== 1'b1 || o_data !== 32'd11 || o_inReady !== 1'b1) begin
            n_err++;
            $display("FAIL unstall: v=%b d=%h r=%b, expected 1 0000000b 1",
                     o_outValid, o_data, o_inReady);
        end
        tick();
        n_vec++;
        if (o_outValid !== 1'b0) begin
            n_err++;
            $display("FAIL unstall_empty: v=%b, expected 0", o_outValid);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'd20, 1'b0);
        tick();
        drive(1'b1, 32'd21, 1'b0);
        tick();
        drive(1'b1, 32'd12, 1'b0);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        n_vec++;
        if (o_outValid !== 1'b0 || o_data !== BUB_V || o_inReady !== 1'b1) begin
            n_err++;
            $display("FAIL flush_skid: v=%b d=%h r=%b, expected 0 %h 1",
                     o_outValid, o_data, o_inReady, BUB_V);
        end
        drive(1'b1, 32'd30, 1'b0);
        tick();
        drive(1'b1, 32'd31, 1'b1);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        n_vec++;
        if (o_outValid !== 1'b0 || o_data !== BUB_V) begin
            n_err++;
            $display("FAIL flush_full: v=%b d=%h, expected 0 %h", o_outValid, o_data, BUB_V);
        end
        tick();
        tick();
        n_vec++;
        if (o_outValid !== 1'b0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL flush_drop: v=%b q=%0d, expected 0 0", o_outValid, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int k = 100;
        for (int c = 0; c < 300; c++) begin
            drive($urandom_range(0, 3) != 0, W'(k), $urandom_range(0, 2) != 0);
            if (i_inValid && o_inReady) k++;
            tick();
        end
        drive(1'b0, 32'h0, 1'b1);
        for (int c = 0; c < 4; c++) tick();
        n_vec++;
        if (exp_q.size() != 0 || o_outValid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_drain: q=%0d v=%b, expected 0 0", exp_q.size(), o_outValid);
        end
    endtask

    task automatic test_flush_reset();
        drive(1'b1, 32'd40, 1'b0);
        tick();
        drive(1'b1, 32'd41, 1'b0);
        reset = 1'b1;
        i_flush = 1'b1;
        tick();
        reset = 1'b0;
        i_flush = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        n_vec++;
        if (o_outValid !== 1'b0 || o_data !== RST_V || o_inReady !== 1'b1) begin
            n_err++;
            $display("FAIL flush_reset: v=%b d=%h r=%b, expected 0 %h 1",
                     o_outValid, o_data, o_inReady, RST_V);
        end
    endtask

`ifdef PIPE_BUBBLE_CNT_EN
    task automatic test_bubble_cnt();
        logic [1:0] e;
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b1);
        tick();
        reset = 1'b0;
        n_vec++;
        if (o_bubbleCnt !== 2'd0) begin
            n_err++;
            $display("FAIL cnt_reset: got %0d, expected 0", o_bubbleCnt);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            e = (i >= 3) ? 2'd3 : 2'(i);
            n_vec++;
            if (o_bubbleCnt !== e) begin
                n_err++;
                $display("FAIL cnt_idle: got %0d, expected %0d", o_bubbleCnt, e);
            end
        end
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        n_vec++;
        if (o_bubbleCnt !== 2'd3) begin
            n_err++;
            $display("FAIL cnt_flush: got %0d, expected 3", o_bubbleCnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_back_to_back();
        test_flush_reset();
`ifdef PIPE_BUBBLE_CNT_EN
        test_bubble_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
